// File: rtl/imem_loader.sv
// Boot-time program loader.
// Accepts a byte stream (header byte N, then 4*N payload bytes) over a
// valid/ready link, packs each group of four bytes little-endian into a
// 32-bit instruction word, and writes it to instruction memory at byte
// address 4*index. The processor core is held in reset until a load
// completes successfully.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BYTES,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Header limit widened by one bit so DEPTH itself (and any header byte)
  // compares unsigned without truncation.
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_cnt;
  logic [7:0]  word_idx;
  logic [7:0]  n_words;
  logic        xfer;

  // A byte moves only when both sides agree in the same cycle.
  assign xfer = rx_valid & rx_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  // NOTE: the default assignment first keeps every path covered, so no
  // latch is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (xfer) begin
          if (rx_data == 8'd0) begin
            state_nxt = S_DONE;
          end else if ({1'b0, rx_data} > DEPTH_LIM) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_BYTES;
          end
        end
      end
      S_BYTES: begin
        if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (word_idx + 8'd1 == n_words) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_BYTES;
        end
      end
      S_DONE: begin
        if (start) state_nxt = S_HDR;
      end
      S_ERR: begin
        if (start) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: header capture, byte-lane packing, address and counters.
  // The address is latched with the fourth byte so it is already stable
  // during the single WRITE cycle together with the completed word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt     <= 2'd0;
      word_idx     <= 8'd0;
      n_words      <= 8'd0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      words_loaded <= 8'd0;
    end else begin
      unique case (state)
        S_HDR: begin
          if (xfer) begin
            n_words      <= rx_data;
            words_loaded <= 8'd0;
            byte_cnt     <= 2'd0;
            word_idx     <= 8'd0;
          end
        end
        S_BYTES: begin
          if (xfer) begin
            mem_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              mem_addr <= {22'd0, word_idx, 2'b00};
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        S_WRITE: begin
          word_idx     <= word_idx + 8'd1;
          words_loaded <= words_loaded + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore output decode of the state register.
  always_comb begin
    rx_ready  = (state == S_HDR) || (state == S_BYTES);
    mem_we    = (state == S_WRITE);
    busy      = (state == S_HDR) || (state == S_BYTES) || (state == S_WRITE);
    done      = (state == S_DONE);
    error     = (state == S_ERR);
    cpu_reset = (state != S_DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// The reference model turns a program (word count plus random words) into
// a byte stream and a queue of expected memory writes; a monitor pops that
// queue whenever the loader strobes mem_we.
module tb_imem_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  words_loaded;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stream[$];
  int         checks = 0;
  int         errors = 0;
  int         we_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      we_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e.addr));
        check("write_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  // Reference model: program of n random words -> byte stream + expected writes.
  task automatic model_program(input int n);
    logic [31:0] w;
    stream.delete();
    stream.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) stream.push_back(8'(w >> (8 * k)));
      exp_q.push_back('{addr: 32'(4 * i), data: w});
    end
  endtask

  // The documented two-word example program.
  task automatic model_fixed();
    stream.delete();
    stream = '{8'h02, 8'h33, 8'h06, 8'h98, 8'h01, 8'h13, 8'h8B, 8'h3A, 8'h00};
    exp_q.push_back('{addr: 32'h0, data: 32'h0198_0633});
    exp_q.push_back('{addr: 32'h4, data: 32'h003A_8B13});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte after an optional idle gap; returns one cycle past the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      waited++;
      if (waited > 100) begin
        checks++;
        errors++;
        $display("FAIL rx_ready_timeout: byte 0x%0h not accepted within 100 cycles", b);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gap_lo, input int gap_hi);
    for (int i = first; i <= last && i < stream.size(); i++) begin
      send_byte(stream[i], (i == first) ? 0 : int'($urandom_range(gap_hi, gap_lo)));
    end
  endtask

  task automatic wait_end();
    int cyc;
    cyc = 0;
    while (!(done || error)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: done/error not reached within 200 cycles");
        return;
      end
    end
  endtask

  task automatic check_done(input string tag, input int n);
    wait_end();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(n));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held, inputs toggling.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start    = i[0];
      rx_valid = ~i[0];
      rx_data  = 8'(i + 1);
      @(negedge clk);
      check("rst_rx_ready", 64'(rx_ready), 64'd0);
      check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      check("rst_flags", 64'({busy, done, error}), 64'd0);
      check("rst_regs", {mem_addr, mem_wdata}, 64'd0);
      check("rst_words", 64'(words_loaded), 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("idle_cpu_reset", 64'(cpu_reset), 64'd1);
    check("idle_rx_ready", 64'(rx_ready), 64'd0);

    // 2: documented stream, back-to-back.
    model_fixed();
    pulse_start();
    check("hdr_busy", 64'(busy), 64'd1);
    send_range(0, 8, 0, 0);
    check_done("fixed", 2);

    // 3: same stream with 1-3 idle cycles between bytes.
    we_pulses = 0;
    model_fixed();
    pulse_start();
    send_range(0, 8, 1, 3);
    check_done("gaps", 2);
    check("gaps_we_pulses", 64'(we_pulses), 64'd2);

    // rx_valid while in DONE is not consumed.
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h05;
    repeat (4) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    check("done_hold", 64'({done, busy}), 64'b10);
    check("done_hold_words", 64'(words_loaded), 64'd2);

    // 4: header boundaries.
    we_pulses = 0;
    pulse_start();
    send_byte(8'h00, 0);
    check("n0_done", 64'(done), 64'd1);
    check("n0_words", 64'(words_loaded), 64'd0);
    check("n0_no_write", 64'(we_pulses), 64'd0);
    pulse_start();
    send_byte(8'h41, 0);
    check("n65_error", 64'(error), 64'd1);
    check("n65_cpu_reset", 64'(cpu_reset), 64'd1);
    check("n65_rx_ready", 64'(rx_ready), 64'd0);
    check("n65_busy", 64'(busy), 64'd0);
    pulse_start();
    check("retry_hdr", 64'({rx_ready, busy, error}), 64'b110);
    send_byte(8'hFF, 0);
    check("nff_error", 64'(error), 64'd1);
    check("err_no_write", 64'(we_pulses), 64'd0);
    model_program(DEPTH);
    pulse_start();
    send_range(0, stream.size() - 1, 0, 1);
    check_done("n64", DEPTH);

    // 5: reset partway through word 0.
    we_pulses = 0;
    model_fixed();
    exp_q.delete();
    pulse_start();
    send_range(0, 2, 0, 0);
    reset = 1'b0;
    #1;
    check("abort_flags", 64'({rx_ready, busy, done, error, cpu_reset}), 64'b00001);
    check("abort_regs", {mem_addr, mem_wdata}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_no_write", 64'(we_pulses), 64'd0);
    model_fixed();
    pulse_start();
    send_range(0, 8, 0, 2);
    check_done("after_abort", 2);

    // 6: start in DONE restarts; start during BYTES is ignored.
    model_program(3);
    pulse_start();
    check("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    check("restart_state", 64'({done, busy, rx_ready}), 64'b011);
    send_range(0, 5, 0, 0);
    pulse_start();
    send_range(6, stream.size() - 1, 0, 0);
    check_done("start_in_bytes", 3);

    // Randomized loads.
    for (int t = 0; t < 5; t++) begin
      int n;
      n = (t == 0) ? 1 : int'($urandom_range(DEPTH, 1));
      model_program(n);
      pulse_start();
      send_range(0, stream.size() - 1, 0, int'($urandom_range(2, 0)));
      check_done("random", n);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
